// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from JK flip-flop stages
//
// Purpose:
//   Loadable synchronous modulo-MODULUS up/down counter. Each bit of q is a JK
//   stage whose J/K inputs are derived every cycle:
//     count : J = K = t   (toggle when all lower bits are 1 going up, 0 going down)
//     load  : J = dl, K = ~dl (set/reset to the clamped load value)
//     wrap  : J/K forced to the wrap target in set/reset mode
//     hold  : J = K = 0
//   Optional feature macro: JK_MOD_COUNTER_SATURATE_EN. When defined, counting
//   saturates at the range ends instead of wrapping, and wrap stays 0.
//
// Parameters:
//   WIDTH   - number of JK stages (bits of q)
//   MODULUS - count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   en   - count enable
//   load - synchronous parallel load (overrides en/up)
//   up   - direction, 1 = increment, 0 = decrement
//   d    - parallel load value (clamped to MODULUS-1)
//   q    - registered count
//   qbar - bitwise complement of q
//   tc   - combinational terminal count
//   wrap - registered one-cycle pulse after a wrap-around

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  // One extra bit on the modulus so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH-1:0] max_q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   mod_ext = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] dl;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_next;
  logic             at_max;
  logic             at_min;
  logic             boundary;
  logic             wrap_take;

  assign q    = q_r;
  assign qbar = ~q_r;
  assign wrap = wrap_r;

  assign at_max   = (q_r == max_q);
  assign at_min   = (q_r == '0);
  assign boundary = up ? at_max : at_min;

  assign tc = en & ~load & ~rst & boundary;

  // Clamp the load value into range.
  assign dl = ({1'b0, d} < mod_ext) ? d : max_q;

  // Toggle conditions: a stage toggles when every lower stage is at 1 (up)
  // or at 0 (down). Stage 0 always toggles while counting.
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q_r[i-1];
      t_dn[i] = t_dn[i-1] & qbar[i-1];
    end
  end

  assign t = up ? t_up : t_dn;

`ifdef JK_MOD_COUNTER_SATURATE_EN
  // Saturating build: at the boundary the stages hold (J = K = 0).
  always_comb begin
    j         = '0;
    k         = '0;
    wrap_take = 1'b0;
    if (load) begin
      j = dl;
      k = ~dl;
    end else if (en) begin
      if (!boundary) begin
        j = t;
        k = t;
      end
    end
  end
`else
  logic [WIDTH-1:0] wrap_target;

  assign wrap_target = up ? '0 : max_q;

  // Wrapping build: at the boundary the stages are driven in set/reset mode
  // to the wrap target; plain toggling would overshoot for non-power-of-2
  // moduli.
  always_comb begin
    j         = '0;
    k         = '0;
    wrap_take = 1'b0;
    if (load) begin
      j = dl;
      k = ~dl;
    end else if (en) begin
      if (boundary) begin
        j         = wrap_target;
        k         = ~wrap_target;
        wrap_take = 1'b1;
      end else begin
        j = t;
        k = t;
      end
    end
  end
`endif

  // JK characteristic equation per stage: Q+ = J & ~Q | ~K & Q.
  assign q_next = (j & ~q_r) | (~k & q_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      wrap_r <= wrap_take;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter

module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  int n_checks;
  int n_fail;

  // Reference state: plain integers updated with arithmetic rules.
  int m_q;
  int m_wrap;

  jk_mod_counter #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .load(load),
    .up  (up),
    .d   (d),
    .q   (q),
    .qbar(qbar),
    .tc  (tc),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_tc(input int r, input int l, input int e, input int u);
    if (r != 0 || l != 0 || e == 0) return 0;
    if (u != 0) return (m_q == MODULUS - 1) ? 1 : 0;
    return (m_q == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int r, input int l, input int e, input int u, input int dv);
    if (r != 0) begin
      m_q = 0; m_wrap = 0;
    end else if (l != 0) begin
      m_q = (dv < MODULUS) ? dv : MODULUS - 1;
      m_wrap = 0;
    end else if (e != 0) begin
      m_wrap = 0;
      if (u != 0) begin
        if (m_q == MODULUS - 1) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
          m_q = MODULUS - 1;
`else
          m_q = 0; m_wrap = 1;
`endif
        end else m_q = m_q + 1;
      end else begin
        if (m_q == 0) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
          m_q = 0;
`else
          m_q = MODULUS - 1; m_wrap = 1;
`endif
        end else m_q = m_q - 1;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // Drive inputs just after an edge, check tc before the next edge, then
  // check registered outputs just after it.
  task automatic step(input string tag, input int r, input int l, input int e,
                      input int u, input int dv);
    rst  = r[0];
    load = l[0];
    en   = e[0];
    up   = u[0];
    d    = dv[WIDTH-1:0];
    #1;
    check({tag, "_tc"}, int'(tc), model_tc(r, l, e, u));
    model_step(r, l, e, u, dv);
    @(posedge clk);
    #1;
    check({tag, "_q"}, int'(q), m_q);
    check({tag, "_qbar"}, int'(qbar), (~m_q) & ((1 << WIDTH) - 1));
    check({tag, "_wrap"}, int'(wrap), m_wrap);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_q      = 0;
    m_wrap   = 0;
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d = '0;
    @(posedge clk);
    #1;

    // Reset wins over load/en.
    step("rst", 1, 1, 1, 1, 5);
    check("rst_q_abs", int'(q), 0);
    check("rst_qbar_abs", int'(qbar), 15);
    for (int i = 0; i < 3; i++) step("up3", 0, 0, 1, 1, 0);
    check("up3_q_abs", int'(q), 3);

    // Wrap upward from 8.
    step("ld8", 0, 1, 0, 0, 8);
    step("up_to9", 0, 0, 1, 1, 0);
    step("up_wrap", 0, 0, 1, 1, 0);
`ifndef JK_MOD_COUNTER_SATURATE_EN
    check("up_wrap_abs", int'(wrap), 1);
`endif
    step("up_after", 0, 0, 1, 1, 0);

    // Load clamp, and load with en set.
    step("ld13", 0, 1, 0, 1, 13);
    check("ld13_abs", int'(q), 9);
    step("ld6", 0, 1, 1, 0, 6);
    check("ld6_abs", int'(q), 6);
    step("ld15", 0, 1, 0, 0, 15);

    // Downward wrap then direction reversal gives back-to-back wraps.
    step("ld1", 0, 1, 0, 0, 1);
    step("dn_to0", 0, 0, 1, 0, 0);
    step("dn_wrap", 0, 0, 1, 0, 0);
    step("rev_wrap", 0, 0, 1, 1, 0);

    // Hold, then reset together with load.
    step("ld7", 0, 1, 0, 0, 7);
    for (int i = 0; i < 4; i++) step("hold", 0, 0, 0, $urandom_range(0, 1), 3);
    step("rst_ld", 1, 1, 0, 0, 4);
    check("rst_ld_abs", int'(q), 0);

    // Randomized traffic biased towards counting.
    for (int i = 0; i < 400; i++) begin
      int r, l, e, u, dv;
      r  = ($urandom_range(0, 49) == 0) ? 1 : 0;
      l  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      u  = ($urandom_range(0, 9) < 6) ? 1 : 0;
      dv = $urandom_range(0, (1 << WIDTH) - 1);
      step("rand", r, l, e, u, dv);
      check("rand_range", (int'(q) < MODULUS) ? 1 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter; every state bit is a JK flip-flop stage with its J/K excitation derived per cycle.
- Sits directly downstream of the single JK flip-flop cell. It consumes that cell's toggle behaviour (J=K=1) and its set/reset behaviour (J≠K) to form a loadable multi-bit counter.
- Drives lab counter/timer exercises, with a terminal-count output for cascading.

Parameters:
- WIDTH, 4, number of JK stages (bits of q).
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- load  input  1  synchronous parallel load.
- up  input  1  direction: 1 = increment, 0 = decrement.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count.
- qbar  output  WIDTH  bitwise complement of q, always ~q.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Only one clock, clk; reset is synchronous and active-high on rst. All state changes happen on the rising edge of clk.
- Priority at each edge: rst > load > en > hold.
- Reset values: q=0, qbar=all ones, wrap=0. tc then follows its equation.
- Stage structure, bit i:
  - Counting: J_i = K_i = t_i.
    - up=1: t_i = AND of q[i-1:0].
    - up=0: t_i = AND of qbar[i-1:0].
    - t_0 = 1.
  - Loading: J_i = dl_i, K_i = ~dl_i.
  - Hold: J_i = K_i = 0.
  - Modulus override: when a wrap is taken, the next state is forced by J/K to the wrap target (set/reset mode), not by toggling.
- Load:
  - q <= d if d < MODULUS, otherwise q <= MODULUS-1 (clamp).
  - wrap <= 0.
  - Load ignores en and up.
- Count up (en=1, up=1):
  - q <= q+1.
  - If q == MODULUS-1: q <= 0 and wrap <= 1.
- Count down (en=1, up=0):
  - q <= q-1.
  - If q == 0: q <= MODULUS-1 and wrap <= 1.
- Hold (en=0, load=0): q unchanged, wrap <= 0.
- wrap is high for exactly one cycle following each wrap edge. Back-to-back wraps (e.g. MODULUS=2 with alternating direction) give consecutive high cycles.
- tc = en & ~load & ~rst & ((up & q==MODULUS-1) | (~up & q==0)). It is combinational, so it is valid in the same cycle the wrap will be taken.
- Direction change: up is sampled at each edge. Reversing direction mid-count steps from the current q with no extra latency.
- rst asserted mid-count or together with load: reset wins, q=0 next cycle.
- q is never outside 0..MODULUS-1 after reset.
- MODULUS = 2^WIDTH: wrap detection still applies, giving natural binary rollover plus the wrap pulse.
- Latency: q reflects inputs one edge after sampling. qbar is combinational from q (zero added latency).

Optional Feature:
- Macro: JK_MOD_COUNTER_SATURATE_EN.
- Defined:
  - Counting saturates instead of wrapping. Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - wrap stays 0 permanently.
  - tc keeps the same equation and flags the saturation boundary.
- Undefined: wrap-around behaviour as specified above.

Test Plan (WIDTH=4, MODULUS=10):
1. rst=1 for 1 edge with en=1, load=1, d=5 → q=0, qbar=4'b1111, wrap=0. Release rst, en=1, up=1 for 3 edges → q=3.
2. From q=8, en=1, up=1:
   - edge 1 → q=9, tc=1 during q=9.
   - edge 2 → q=0, wrap=1 for one cycle.
   - edge 3 → q=1, wrap=0.
3. load=1, d=4'd13 → q=9 (clamped). Then load=1, d=4'd6 with en=1 → q=6, wrap=0.
4. From q=1, en=1, up=0:
   - edge 1 → q=0, tc=1.
   - edge 2 → q=9, wrap=1.
   - Then set up=1 → next edge q=0 with wrap=1 again.
5. q=7, en=0 for 4 edges → q stays 7, tc=0, wrap=0. Next, rst=1 and load=1 asserted together → q=0.
6. With JK_MOD_COUNTER_SATURATE_EN defined, from q=8, up=1, en=1 for 3 edges → q=9, 9, 9, wrap never 1. Then up=0 → q=8.
